// File: rtl/picorv32_ifetch_line_buffer.sv
// One-line instruction prefetch buffer between the PicoRV32 native bus and the FreeAHB adapter.
// Fetch misses refill the whole line word by word; data accesses pass straight through.
`timescale 1ns/1ps
module picorv32_ifetch_line_buffer #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inv,
  input  logic              mem_valid,
  input  logic              mem_instr,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  output logic              dn_valid,
  output logic              dn_instr,
  input  logic              dn_ready,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [31:0]       dn_wdata,
  output logic [3:0]        dn_wstrb,
  input  logic [31:0]       dn_rdata
);

  localparam int unsigned IdxW = $clog2(LINE_WORDS);
  localparam int unsigned TagW = ADDR_W - IdxW - 2;

  typedef enum logic [2:0] {StIdle, StFill, StFgap, StFresp, StPass, StRgap} state_e;

  state_e            state_q, state_d;
  logic              line_valid_q, line_valid_d;
  logic [IdxW-1:0]   fill_ctr_q, fill_ctr_d;
  logic              inv_seen_q, inv_seen_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              mem_ready_q, mem_ready_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              dn_valid_q, dn_valid_d;
  logic              dn_instr_q, dn_instr_d;
  logic [ADDR_W-1:0] dn_addr_q, dn_addr_d;
  logic [31:0]       dn_wdata_q, dn_wdata_d;
  logic [3:0]        dn_wstrb_q, dn_wstrb_d;
  logic [31:0]       line_q [LINE_WORDS];
  logic [31:0]       line_d [LINE_WORDS];
  logic [TagW-1:0]   tag_q, tag_d;

  logic [TagW-1:0] req_tag;
  logic [IdxW-1:0] req_idx;
  logic [TagW-1:0] fill_tag;
  logic [IdxW-1:0] fill_idx;
  logic            tag_match;
  logic            hit;
  logic            fill_last;

  assign req_tag   = mem_addr[ADDR_W-1 -: TagW];
  assign req_idx   = mem_addr[IdxW+1:2];
  assign fill_tag  = req_addr_q[ADDR_W-1 -: TagW];
  assign fill_idx  = req_addr_q[IdxW+1:2];
  assign tag_match = (tag_q == req_tag);
  // inv wins over a lookup in the same cycle
  assign hit       = line_valid_q && tag_match && !inv;
  assign fill_last = (fill_ctr_q == IdxW'(LINE_WORDS - 1));

  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    fill_ctr_d   = fill_ctr_q;
    inv_seen_d   = inv_seen_q | inv;
    req_addr_d   = req_addr_q;
    mem_ready_d  = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    dn_valid_d   = dn_valid_q;
    dn_instr_d   = dn_instr_q;
    dn_addr_d    = dn_addr_q;
    dn_wdata_d   = dn_wdata_q;
    dn_wstrb_d   = dn_wstrb_q;
    line_d       = line_q;
    tag_d        = tag_q;

    unique case (state_q)
      StIdle: begin
        if (mem_valid) begin
          if (mem_instr && (mem_wstrb == 4'b0000)) begin
            if (hit) begin
              mem_rdata_d = line_q[req_idx];
              mem_ready_d = 1'b1;
              state_d     = StRgap;
            end else begin
              req_addr_d = mem_addr;
              fill_ctr_d = '0;
              inv_seen_d = 1'b0;
              dn_valid_d = 1'b1;
              dn_instr_d = 1'b1;
              dn_wstrb_d = 4'b0000;
              dn_addr_d  = {req_tag, {IdxW{1'b0}}, 2'b00};
              state_d    = StFill;
            end
          end else begin
            dn_valid_d = 1'b1;
            dn_instr_d = mem_instr;
            dn_addr_d  = mem_addr;
            dn_wdata_d = mem_wdata;
            dn_wstrb_d = mem_wstrb;
            state_d    = StPass;
            if ((mem_wstrb != 4'b0000) && tag_match) begin
              line_valid_d = 1'b0;
            end
          end
        end
      end
      StFill: begin
        if (dn_valid_q && dn_ready) begin
          line_d[fill_ctr_q] = dn_rdata;
          dn_valid_d         = 1'b0;
          state_d            = StFgap;
        end
      end
      StFgap: begin
        if (fill_last) begin
          tag_d        = fill_tag;
          line_valid_d = !inv_seen_q;
          state_d      = StFresp;
        end else begin
          fill_ctr_d = fill_ctr_q + 1'b1;
          dn_valid_d = 1'b1;
          dn_addr_d  = {fill_tag, fill_ctr_d, 2'b00};
          state_d    = StFill;
        end
      end
      StFresp: begin
        mem_rdata_d = line_q[fill_idx];
        mem_ready_d = 1'b1;
        state_d     = StRgap;
      end
      StPass: begin
        if (dn_valid_q && dn_ready) begin
          mem_rdata_d = dn_rdata;
          mem_ready_d = 1'b1;
          dn_valid_d  = 1'b0;
          state_d     = StRgap;
        end
      end
      StRgap: begin
        // the core drops mem_valid after the ready cycle, so it is ignored here
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (inv) begin
      line_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      line_valid_q <= 1'b0;
      fill_ctr_q   <= '0;
      inv_seen_q   <= 1'b0;
      req_addr_q   <= '0;
      mem_ready_q  <= 1'b0;
      mem_rdata_q  <= '0;
      dn_valid_q   <= 1'b0;
      dn_instr_q   <= 1'b0;
      dn_addr_q    <= '0;
      dn_wdata_q   <= '0;
      dn_wstrb_q   <= '0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      fill_ctr_q   <= fill_ctr_d;
      inv_seen_q   <= inv_seen_d;
      req_addr_q   <= req_addr_d;
      mem_ready_q  <= mem_ready_d;
      mem_rdata_q  <= mem_rdata_d;
      dn_valid_q   <= dn_valid_d;
      dn_instr_q   <= dn_instr_d;
      dn_addr_q    <= dn_addr_d;
      dn_wdata_q   <= dn_wdata_d;
      dn_wstrb_q   <= dn_wstrb_d;
    end
  end

  // Line storage and tag carry no reset; line_valid qualifies them.
  always_ff @(posedge clk) begin
    line_q <= line_d;
    tag_q  <= tag_d;
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign dn_valid  = dn_valid_q;
  assign dn_instr  = dn_instr_q;
  assign dn_addr   = dn_addr_q;
  assign dn_wdata  = dn_wdata_q;
  assign dn_wstrb  = dn_wstrb_q;

endmodule
